// File: rtl/sdec_win_pkg.sv
// Shared definitions for the windowed stochastic decoders.
//   state_e  : decoder FSM states (idle / counting a window)
//   MODE_*   : output encoding select (unipolar count, bipolar offset count)
package sdec_win_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam logic MODE_UNI = 1'b0;
  localparam logic MODE_BIP = 1'b1;

endpackage

// File: rtl/sdec_sat.sv
// Saturating window-count to N-bit value converter.
//   s     in  N+1  ones counted over a 2^N window, range [0, 2^N]
//   mode  in  1    MODE_UNI: value = s, MODE_BIP: value = s - 2^(N-1) (two's complement)
//   value out N    result, clamped to the representable range
module sdec_sat
  import sdec_win_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [N:0]   s,
  input  logic         mode,
  output logic [N-1:0] value
);

  localparam logic [N:0]   FULL   = {1'b1, {N{1'b0}}};
  localparam logic [N-1:0] HALF   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] POSMAX = {1'b0, {(N-1){1'b1}}};

  always_comb begin
    value = s[N-1:0];
    if (mode == MODE_BIP) begin
      // Only s == 2^N overflows; for every other s the low N bits minus
      // the offset wrap to the correct two's complement value (s=0 -> -2^(N-1)).
      value = (s == FULL) ? POSMAX : (s[N-1:0] - HALF);
    end else if (s == FULL) begin
      value = '1;
    end
  end

endmodule

// File: rtl/sdec_win.sv
// Windowed stochastic-to-binary decoder with start/busy/done handshake.
// Counts ones of bit_in over 2^N cycles and returns an N-bit value.
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active low
//   start  in   begin a window (sampled in IDLE only)
//   cont   in   chain the next window directly (sampled on last sample)
//   mode   in   0 unipolar, 1 bipolar (sampled on last sample)
//   bit_in in   stochastic bitstream, one sample per clk
//   busy   out  window in progress
//   done   out  one-cycle pulse, value updated together with it
//   value  out  decoded result, held until the next done
module sdec_win
  import sdec_win_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cont,
  input  logic         mode,
  input  logic         bit_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] value
);

  state_e         state_q, state_d;
  logic [N-1:0]   phase_q, phase_d;
  logic [N:0]     ones_q,  ones_d;
  logic [N-1:0]   value_q, value_d;
  logic           done_q,  done_d;

  logic           last;
  logic [N:0]     s;
  logic [N-1:0]   sat_val;

  assign last = (phase_q == {N{1'b1}});
  // Running total including this cycle's sample; on the last sample it is
  // the full window count (up to 2^N, hence N+1 bits).
  assign s    = ones_q + {{N{1'b0}}, bit_in};

  sdec_sat #(.N(N)) u_sat (
    .s     (s),
    .mode  (mode),
    .value (sat_val)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ones_d  = ones_q;
    value_d = value_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // bit_in in the start cycle is deliberately not counted.
        if (start) begin
          ones_d  = '0;
          phase_d = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        ones_d  = s;
        phase_d = phase_q + {{(N-1){1'b0}}, 1'b1};
        if (last) begin
          value_d = sat_val;
          done_d  = 1'b1;
          // phase wraps to 0 by itself; clearing ones lets a continuous
          // window take its first sample in the very next cycle.
          ones_d  = '0;
          if (!cont) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      ones_q  <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ones_q  <= ones_d;
      value_q <= value_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == ST_COUNT);
  assign done  = done_q;
  assign value = value_q;

endmodule

// File: tb/tb_sdec_win.sv
module tb_sdec_win;

  localparam int N  = 10;
  localparam int W  = 1 << N;
  localparam int N4 = 4;
  localparam int W4 = 1 << N4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, cont = 1'b0, mode = 1'b0, bit_in = 1'b0;
  logic busy, done;
  logic [N-1:0] value;

  logic start4 = 1'b0, cont4 = 1'b0, mode4 = 1'b0, bit4 = 1'b0;
  logic busy4, done4;
  logic [N4-1:0] value4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sdec_win #(.N(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mode(mode),
    .bit_in(bit_in), .busy(busy), .done(done), .value(value)
  );

  sdec_win #(.N(N4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .cont(cont4), .mode(mode4),
    .bit_in(bit4), .busy(busy4), .done(done4), .value(value4)
  );

  // Reference decode: count of ones -> expected output word.
  function automatic int model_val(input int ones, input int md, input int n);
    int full, half, d;
    full = 1 << n;
    half = 1 << (n - 1);
    if (md == 0) return (ones == full) ? full - 1 : ones;
    d = ones - half;
    if (d == half) d = half - 1;
    return d & (full - 1);
  endfunction

  // pat: 0 all ones, 1 all zeros, 2 alternating 1,0, else random with thr% density
  function automatic bit gen(input int pat, input int i, input int thr);
    case (pat)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2 == 0);
      default: return ($urandom_range(0, 99) < thr);
    endcase
  endfunction

  // One full window on the N=10 instance. mode is scrambled during the
  // window and only set to md on the last sample; bit_in is 1 in the start
  // cycle, which must not be counted.
  task automatic run_win(input string nm, input int md, input int pat,
                         input int thr, input int repulse_at);
    int ones;
    int exp_v;
    bit bad;
    bit b;
    ones = 0;
    bad  = 1'b0;
    cont = 1'b0;
    mode = md[0];
    bit_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < W; i++) begin
      b = gen(pat, i, thr);
      bit_in = b;
      ones += int'(b);
      start = (i == repulse_at);
      mode = (i == W - 1) ? md[0] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (i < W - 1 && (busy !== 1'b1 || done !== 1'b0)) bad = 1'b1;
    end
    start = 1'b0;
    exp_v = model_val(ones, md, N);
    checks++;
    if (bad) $display("FAIL %s_inwin busy/done wrong during window", nm);
    else passes++;
    checks++;
    if (done !== 1'b1) $display("FAIL %s_done got %0b exp 1 at start+%0d", nm, done, W + 1);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_busy got %0b exp 0", nm, busy);
    else passes++;
    checks++;
    if (value !== N'(exp_v)) $display("FAIL %s_value got %0d exp %0d", nm, value, exp_v);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || value !== N'(exp_v))
      $display("FAIL %s_pulse done got %0b exp 0, value got %0d exp %0d", nm, done, value, exp_v);
    else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || value !== '0)
      $display("FAIL reset got busy=%0b done=%0b value=%0d exp 0/0/0", busy, done, value);
    else passes++;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || value4 !== '0)
      $display("FAIL reset4 got busy=%0b done=%0b value=%0d exp 0/0/0", busy4, done4, value4);
    else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_const;
    run_win("ones_uni", 0, 0, 0, -1);
    run_win("ones_bip", 1, 0, 0, -1);
    run_win("zeros_bip", 1, 1, 0, -1);
    run_win("zeros_uni", 0, 1, 0, -1);
  endtask

  task automatic test_alternating;
    run_win("alt_uni", 0, 2, 0, -1);
    run_win("alt_bip", 1, 2, 0, -1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++)
      run_win("rand", int'($urandom_range(0, 1)), 3, int'($urandom_range(0, 100)),
              int'($urandom_range(0, W - 2)));
  endtask

  // N=4, cont=1: 16 ones then 16 zeros back to back.
  task automatic test_back_to_back;
    int exp_v;
    bit exp_done, exp_busy;
    mode4 = 1'b0;
    cont4 = 1'b1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 0; i < 2 * W4; i++) begin
      bit4 = (i < W4);
      cont4 = (i < 2 * W4 - 1);
      @(posedge clk); #1;
      exp_done = (i == W4 - 1) || (i == 2 * W4 - 1);
      exp_busy = (i < 2 * W4 - 1);
      checks++;
      if (done4 !== exp_done || busy4 !== exp_busy)
        $display("FAIL b2b_hs[%0d] done got %0b exp %0b busy got %0b exp %0b",
                 i, done4, exp_done, busy4, exp_busy);
      else passes++;
      if (exp_done) begin
        exp_v = (i == W4 - 1) ? model_val(W4, 0, N4) : model_val(0, 0, N4);
        checks++;
        if (value4 !== N4'(exp_v)) $display("FAIL b2b_value[%0d] got %0d exp %0d", i, value4, exp_v);
        else passes++;
      end
    end
    bit4 = 1'b0;
  endtask

  // start re-pulse mid-window, then async reset at phase 7.
  task automatic test_abort;
    int pulses;
    bit bsy;
    run_win("pre_abort", 0, 0, 0, -1);
    bit_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      start = (i == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || value !== '0)
      $display("FAIL abort got busy=%0b done=%0b value=%0d exp 0/0/0", busy, done, value);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0;
    bsy = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (busy !== 1'b0) bsy = 1'b1;
    end
    checks++;
    if (pulses != 0 || bsy || value !== '0)
      $display("FAIL abort_quiet got pulses=%0d busy_seen=%0b value=%0d exp 0/0/0", pulses, bsy, value);
    else passes++;
    run_win("post_abort", 1, 3, 70, 500);
  endtask

  initial begin
    test_reset();
    test_const();
    test_alternating();
    test_random();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
